arith_share_ctrl: RTL and testbench

- Round-robin scheduler that shares one multi-cycle add/multiply datapath between NUM_REQ requesters.
- Each requester uses a valid/ready request handshake. The block grants one request, sequences the shared unit, and returns the result tagged with the requester ID.
- Sits between the per-channel compute clients and the single arithmetic resource.
- Exactly one operation is in flight at a time.

---
 rtl/arith_share_ctrl_pkg.sv | 16 +
 rtl/arith_share_ctrl_rr_arbiter.sv | 30 +++
 rtl/arith_share_ctrl.sv | 118 +++++++++++
 tb/tb_arith_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_share_ctrl_pkg.sv
// rtl/arith_share_ctrl_pkg.sv - shared state/op encodings for the arithmetic share controller
package arith_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Wide enough for MUL_LAT-1 with MUL_LAT up to 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/arith_share_ctrl_rr_arbiter.sv
// rtl/arith_share_ctrl_rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/arith_share_ctrl.sv
// rtl/arith_share_ctrl.sv - round-robin sharing of one multi-cycle add/mult unit among NUM_REQ requesters
module arith_share_ctrl
    import arith_share_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic                     busy
);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 arb_en;
    logic                 accept;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 op_q;
    logic [ID_W-1:0]      owner_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [2*WIDTH-1:0]   rsp_data_q;
    logic [2*WIDTH-1:0]   result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    assign result = (op_q == OP_MUL) ? ((2*WIDTH)'(a_q) * (2*WIDTH)'(b_q))
                                     : ((2*WIDTH)'(a_q) + (2*WIDTH)'(b_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)         state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == '0)    state_d = ST_RESP;
            ST_RESP: if (rsp_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Grants are masked while reset is asserted so every output reads 0 during reset
    always_comb begin
        arb_en    = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: arb_en = rst_n;
            ST_EXEC: busy   = 1'b1;
            ST_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            owner_q    <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else if (accept) begin
            a_q     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            b_q     <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
            op_q    <= req_op[grant_idx];
            owner_q <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            cnt_q   <= (req_op[grant_idx] == OP_MUL) ? CNT_W'(MUL_LAT-1) : '0;
        end else if (state_q == ST_EXEC) begin
            if (cnt_q == '0) begin
                rsp_id_q   <= owner_q;
                rsp_data_q <= result;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arith_share_ctrl.sv
// tb/tb_arith_share_ctrl.sv - self-checking bench for arith_share_ctrl with a transaction-level model
module tb_arith_share_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = 8;
    localparam int ML = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid, req_ready, req_op;
    logic [N*W-1:0]   req_a, req_b;
    logic             rsp_valid, rsp_ready, busy;
    logic [IW-1:0]    rsp_id;
    logic [2*W-1:0]   rsp_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_ids[$];
    int acc_edges[$];
    int rv_edges[$];

    // Model: which requester owns the unit, how many EXEC cycles remain, pending result
    bit m_idle = 1'b1;
    bit m_resp = 1'b0;
    int m_left = 0;
    int m_ptr  = 0;
    int m_id   = 0;
    int m_data = 0;
    bit prev_rv = 1'b0;

    arith_share_ctrl #(.NUM_REQ(N), .ID_W(IW), .WIDTH(W), .MUL_LAT(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        int g, a, b;
        logic [N-1:0] eg;
        @(negedge clk);
        if (!rst_n) begin
            m_idle = 1'b1; m_resp = 1'b0; m_ptr = 0; m_left = 0; prev_rv = 1'b0;
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
        end else begin
            g = -1;
            if (m_idle)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(eg));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("rsp_id", 32'(rsp_id), m_id);
                chk("rsp_data", 32'(rsp_data), m_data);
            end
            if (|(req_valid & req_ready)) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) acc_ids.push_back(k);
                acc_edges.push_back(cyc + 1);
            end
            if (rsp_valid && !prev_rv) rv_edges.push_back(cyc);
            prev_rv = rsp_valid;
            if (m_idle) begin
                if (g >= 0) begin
                    a = int'(req_a[g*W +: W]);
                    b = int'(req_b[g*W +: W]);
                    m_idle = 1'b0;
                    m_id   = g;
                    m_data = req_op[g] ? a * b : a + b;
                    m_left = req_op[g] ? ML : 1;
                    m_ptr  = (g + 1) % N;
                end
            end else if (!m_resp) begin
                m_left--;
                if (m_left == 0) m_resp = 1'b1;
            end else if (rsp_ready) begin
                m_resp = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    task automatic wait_acc(input int n);
        for (int i = 0; i < 300 && acc_ids.size() < n; i++) begin
            @(negedge clk); #1;
        end
        chk("accept_wait", 32'(acc_ids.size() >= n), 1);
    endtask

    task automatic wait_rv(input int n);
        for (int i = 0; i < 300 && rv_edges.size() < n; i++) begin
            @(negedge clk); #1;
        end
        chk("rsp_wait", 32'(rv_edges.size() >= n), 1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 300 && (busy !== 1'b0 || rsp_valid !== 1'b0)) begin
            @(negedge clk); #1;
            i++;
        end
        chk("idle_wait", 32'(busy === 1'b0 && rsp_valid === 1'b0), 1);
    endtask

    task automatic set_req(input int id, input int op, input int a, input int b);
        req_op[id]       = op[0];
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
    endtask

    task automatic run_single(input int id, input int op, input int a, input int b,
                              input int exp_lat, input int exp_data, input string tag);
        int na, nr;
        logic [N-1:0] oh;
        na = acc_ids.size();
        nr = rv_edges.size();
        oh = '0;
        oh[id] = 1'b1;
        @(posedge clk); #1;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        #1 chk({tag, "_grant"}, 32'(req_ready), 32'(oh));
        wait_acc(na + 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 1);
        wait_rv(nr + 1);
        if (acc_ids.size() > na && rv_edges.size() > nr) begin
            chk({tag, "_acc_id"}, acc_ids[na], id);
            chk({tag, "_latency"}, rv_edges[nr] - acc_edges[na], exp_lat);
        end
        chk({tag, "_rsp_id"}, 32'(rsp_id), id);
        chk({tag, "_rsp_data"}, 32'(rsp_data), exp_data);
    endtask

    initial begin
        int na, nr;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_data", 32'(rsp_data), 0);

        run_single(2, 1, 200, 250, 3, 50000, "mul200x250");
        wait_idle();
        run_single(0, 0, 255, 255, 1, 510, "add255");
        wait_idle();
        run_single(3, 0, 7, 9, 1, 16, "add_r3");
        wait_idle();

        // All requesters valid: rotation starts at 0 since 3 was granted last
        na = acc_ids.size();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_req(i, 0, 10*i + 1, 100 + i);
        req_valid = 4'b1111;
        wait_acc(na + 5);
        @(posedge clk); #1;
        req_valid = '0;
        if (acc_ids.size() >= na + 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", acc_ids[na+k], k % N);
            for (int k = 1; k < 5; k++) chk("rr_spacing", acc_edges[na+k] - acc_edges[na+k-1], 3);
        end
        wait_idle();

        // Back-pressure: response held while 1 and 3 wait
        na = acc_ids.size();
        nr = rv_edges.size();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(0, 0, 5, 6);
        req_valid = 4'b0001;
        wait_acc(na + 1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_rv(nr + 1);
        @(posedge clk); #1;
        req_valid = 4'b1010;
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_id", 32'(rsp_id), 0);
            chk("bp_rsp_data", 32'(rsp_data), 11);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_acc(na + 2);
        if (acc_ids.size() > na + 1) chk("bp_next_grant", acc_ids[na+1], 1);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        wait_acc(na + 3);
        if (acc_ids.size() > na + 2) chk("bp_then_grant", acc_ids[na+2], 3);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Reset in the middle of a multiply
        na = acc_ids.size();
        @(posedge clk); #1;
        set_req(2, 1, 15, 15);
        req_valid = 4'b0100;
        wait_acc(na + 1);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rst_req_ready", 32'(req_ready), 0);
        chk("async_rst_rsp_id", 32'(rsp_id), 0);
        chk("async_rst_rsp_data", 32'(rsp_data), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nr = rv_edges.size();
        wait_acc(na + 2);
        if (acc_ids.size() > na + 1) chk("post_rst_grant", acc_ids[na+1], 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        chk("post_rst_rsp_count", rv_edges.size(), nr + 1);

        // Requester 1 withdraws while 0 is serviced; 2 must be next
        run_single(3, 0, 1, 2, 1, 3, "add_r3b");
        wait_idle();
        na = acc_ids.size();
        @(posedge clk); #1;
        req_op = '0;
        req_valid = 4'b0111;
        wait_acc(na + 1);
        @(posedge clk); #1;
        req_valid = 4'b0110;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        wait_acc(na + 2);
        if (acc_ids.size() > na + 1) begin
            chk("skip_first", acc_ids[na], 0);
            chk("skip_next", acc_ids[na+1], 2);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
